// File: rtl/ttc_chanb_pkg.sv
// Shared constants and FSM encoding for the TTC Channel B command decoder.
// Holds Brcst bit positions, the timestamp-reset pattern and fill FSM states.
package ttc_chanb_pkg;

  localparam int FLAG_BIT     = 1;
  localparam int FILL_SEL_BIT = 5;

  localparam logic [2:0] TS_PATTERN = 3'b001;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } fill_state_e;

endpackage

// File: rtl/chanb_sat_counter.sv
// Saturating up-counter for slow-control statistics.
// Ports: clk, reset (sync, active-high), inc (count enable), count (value).
module chanb_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/ttc_chanb_cmd_decoder.sv
// TTC Channel B broadcast decoder: reset strobes, staged fill type, counters.
// Ports: clk, reset (sync, active-high), chan_b_info/evt_count_reset/
// chan_b_valid from the TTC decoder, trig_idle from the trigger manager;
// outputs fill_type, fill_pending, reset_trig_num, reset_trig_timestamp,
// cmd_error and five num_* counters. Counters exist only when
// CHANB_CMD_COUNTERS_EN is defined; otherwise num_* read as zero.
module ttc_chanb_cmd_decoder
  import ttc_chanb_pkg::*;
#(
  parameter int FILL_TYPE_W  = 2,
  parameter int DEFAULT_FILL = 1,
  parameter int CNT_W        = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [5:0]             chan_b_info,
  input  logic                   evt_count_reset,
  input  logic                   chan_b_valid,
  input  logic                   trig_idle,
  output logic [FILL_TYPE_W-1:0] fill_type,
  output logic                   fill_pending,
  output logic                   reset_trig_num,
  output logic                   reset_trig_timestamp,
  output logic                   cmd_error,
  output logic [CNT_W-1:0]       num_fill_cmds,
  output logic [CNT_W-1:0]       num_ts_resets,
  output logic [CNT_W-1:0]       num_num_resets,
  output logic [CNT_W-1:0]       num_errors,
  output logic [CNT_W-1:0]       num_overwrites
);

  localparam logic [FILL_TYPE_W-1:0] DEF_FILL =
    FILL_TYPE_W'(DEFAULT_FILL);

  logic [FILL_TYPE_W-1:0] field;
  logic [FILL_TYPE_W-1:0] pend_q;
  logic is_num, is_ts, is_fill;
  logic fill_ok, fill_bad;
  logic apply, overwrite;
  fill_state_e state_q, state_d;

  // Bit 0 never participates; bit 2 only for 3-bit fill fields.
  logic unused_bits;
  assign unused_bits = ^{chan_b_info[0], chan_b_info[2]};

  assign field = chan_b_info[4 -: FILL_TYPE_W];

  assign is_num  = chan_b_valid & evt_count_reset;
  assign is_ts   = chan_b_valid
                 & (chan_b_info[5:3] == TS_PATTERN)
                 & chan_b_info[FLAG_BIT];
  assign is_fill = chan_b_valid
                 & chan_b_info[FILL_SEL_BIT]
                 & ~chan_b_info[FLAG_BIT];
  assign fill_ok  = is_fill & (field != '0);
  assign fill_bad = is_fill & (field == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A command arriving together with trig_idle keeps us pending.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (fill_ok) state_d = ST_PENDING;
      ST_PENDING: if (trig_idle && !fill_ok) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    fill_pending = 1'b0;
    apply        = 1'b0;
    overwrite    = 1'b0;
    if (state_q == ST_PENDING) begin
      fill_pending = 1'b1;
      apply        = trig_idle;
      overwrite    = fill_ok & ~trig_idle;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fill_type <= DEF_FILL;
      pend_q    <= DEF_FILL;
    end else begin
      if (apply) fill_type <= pend_q;
      if (fill_ok) pend_q <= field;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      reset_trig_num       <= 1'b0;
      reset_trig_timestamp <= 1'b0;
      cmd_error            <= 1'b0;
    end else begin
      reset_trig_num       <= is_num;
      reset_trig_timestamp <= is_ts;
      cmd_error            <= fill_bad;
    end
  end

`ifdef CHANB_CMD_COUNTERS_EN
  chanb_sat_counter #(.W(CNT_W)) u_cnt_fill (
    .clk(clk), .reset(reset), .inc(fill_ok), .count(num_fill_cmds)
  );
  chanb_sat_counter #(.W(CNT_W)) u_cnt_ts (
    .clk(clk), .reset(reset), .inc(is_ts), .count(num_ts_resets)
  );
  chanb_sat_counter #(.W(CNT_W)) u_cnt_num (
    .clk(clk), .reset(reset), .inc(is_num), .count(num_num_resets)
  );
  chanb_sat_counter #(.W(CNT_W)) u_cnt_err (
    .clk(clk), .reset(reset), .inc(fill_bad), .count(num_errors)
  );
  chanb_sat_counter #(.W(CNT_W)) u_cnt_ovw (
    .clk(clk), .reset(reset), .inc(overwrite), .count(num_overwrites)
  );
`else
  assign num_fill_cmds  = '0;
  assign num_ts_resets  = '0;
  assign num_num_resets = '0;
  assign num_errors     = '0;
  assign num_overwrites = '0;
`endif

endmodule

// File: tb/tb_ttc_chanb_cmd_decoder.sv
// Scoreboard bench for ttc_chanb_cmd_decoder (CNT_W=16 and CNT_W=2 copies).
// Stimulus pushes hand-computed expectations; a monitor pops and compares.
module tb_ttc_chanb_cmd_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] chan_b_info = '0;
  logic       evt_count_reset = 1'b0;
  logic       chan_b_valid = 1'b0;
  logic       trig_idle = 1'b0;

  logic [1:0]  fill_type;
  logic        fill_pending, reset_trig_num;
  logic        reset_trig_timestamp, cmd_error;
  logic [15:0] n_fill, n_ts, n_num, n_err, n_ovw;

  logic [1:0] fill_type2;
  logic       fill_pending2, rtn2, rts2, err2;
  logic [1:0] m_fill, m_ts, m_num, m_err, m_ovw;

  always #5 clk = ~clk;

  ttc_chanb_cmd_decoder #(
    .FILL_TYPE_W(2), .DEFAULT_FILL(1), .CNT_W(16)
  ) dut (
    .clk(clk), .reset(reset),
    .chan_b_info(chan_b_info),
    .evt_count_reset(evt_count_reset),
    .chan_b_valid(chan_b_valid),
    .trig_idle(trig_idle),
    .fill_type(fill_type),
    .fill_pending(fill_pending),
    .reset_trig_num(reset_trig_num),
    .reset_trig_timestamp(reset_trig_timestamp),
    .cmd_error(cmd_error),
    .num_fill_cmds(n_fill),
    .num_ts_resets(n_ts),
    .num_num_resets(n_num),
    .num_errors(n_err),
    .num_overwrites(n_ovw)
  );

  ttc_chanb_cmd_decoder #(
    .FILL_TYPE_W(2), .DEFAULT_FILL(1), .CNT_W(2)
  ) dut2 (
    .clk(clk), .reset(reset),
    .chan_b_info(chan_b_info),
    .evt_count_reset(evt_count_reset),
    .chan_b_valid(chan_b_valid),
    .trig_idle(trig_idle),
    .fill_type(fill_type2),
    .fill_pending(fill_pending2),
    .reset_trig_num(rtn2),
    .reset_trig_timestamp(rts2),
    .cmd_error(err2),
    .num_fill_cmds(m_fill),
    .num_ts_resets(m_ts),
    .num_num_resets(m_num),
    .num_errors(m_err),
    .num_overwrites(m_ovw)
  );

  typedef struct {
    int ft, fp, rn, rs, er;
    int cf, ct, cn, ce, co, ct2;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;
  int ec_fill, ec_ts, ec_num, ec_err, ec_ovw;

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               n, act, exp, $time);
    end
  endtask

  // Monitor: results of the inputs applied before this edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("fill_type", int'(fill_type), e.ft);
      chk("fill_pending", int'(fill_pending), e.fp);
      chk("reset_trig_num", int'(reset_trig_num), e.rn);
      chk("reset_trig_ts", int'(reset_trig_timestamp), e.rs);
      chk("cmd_error", int'(cmd_error), e.er);
      chk("num_fill_cmds", int'(n_fill), e.cf);
      chk("num_ts_resets", int'(n_ts), e.ct);
      chk("num_num_resets", int'(n_num), e.cn);
      chk("num_errors", int'(n_err), e.ce);
      chk("num_overwrites", int'(n_ovw), e.co);
      chk("num_ts_resets_w2", int'(m_ts), e.ct2);
    end
  end

  task automatic step(
    input bit rs, input bit v, input bit [5:0] info,
    input bit ecr, input bit ti,
    input int eft, input int efp,
    input int ern, input int ers, input int eer
  );
    exp_t e;
    @(negedge clk);
    reset = rs;
    chan_b_valid = v;
    chan_b_info = info;
    evt_count_reset = ecr;
    trig_idle = ti;
    e.ft = eft; e.fp = efp;
    e.rn = ern; e.rs = ers; e.er = eer;
`ifdef CHANB_CMD_COUNTERS_EN
    e.cf = ec_fill; e.ct = ec_ts; e.cn = ec_num;
    e.ce = ec_err; e.co = ec_ovw;
    e.ct2 = (ec_ts > 3) ? 3 : ec_ts;
`else
    e.cf = 0; e.ct = 0; e.cn = 0;
    e.ce = 0; e.co = 0; e.ct2 = 0;
`endif
    q.push_back(e);
  endtask

  task automatic clr();
    ec_fill = 0; ec_ts = 0; ec_num = 0;
    ec_err = 0; ec_ovw = 0;
  endtask

  initial begin
    clr();
    repeat (3) step(1, 0, 6'b000000, 0, 0, 1, 0, 0, 0, 0);
    repeat (10) step(0, 0, 6'b000000, 0, 0, 1, 0, 0, 0, 0);

    // Timestamp and number reset together
    ec_ts++; ec_num++;
    step(0, 1, 6'b001010, 1, 0, 1, 0, 1, 1, 0);
    step(0, 0, 6'b000000, 0, 0, 1, 0, 0, 0, 0);

    // Fill 2 staged, applied after trig_idle
    ec_fill++;
    step(0, 1, 6'b110000, 0, 0, 1, 1, 0, 0, 0);
    repeat (4) step(0, 0, 6'b000000, 0, 0, 1, 1, 0, 0, 0);
    step(0, 0, 6'b000000, 0, 1, 2, 0, 0, 0, 0);
    step(0, 0, 6'b000000, 0, 1, 2, 0, 0, 0, 0);

    // Overwrite: 2 then 3, latest wins
    ec_fill++;
    step(0, 1, 6'b110000, 0, 0, 2, 1, 0, 0, 0);
    ec_fill++; ec_ovw++;
    step(0, 1, 6'b111000, 0, 0, 2, 1, 0, 0, 0);
    step(0, 0, 6'b000000, 0, 1, 3, 0, 0, 0, 0);

    // Command and trig_idle together: apply old, stage new
    ec_fill++;
    step(0, 1, 6'b110000, 0, 0, 3, 1, 0, 0, 0);
    ec_fill++;
    step(0, 1, 6'b111000, 0, 1, 2, 1, 0, 0, 0);
    step(0, 0, 6'b000000, 0, 1, 3, 0, 0, 0, 0);

    // Illegal fill field 0
    ec_err++;
    step(0, 1, 6'b100000, 0, 0, 3, 0, 0, 0, 1);
    step(0, 0, 6'b000000, 0, 0, 3, 0, 0, 0, 0);

    // Ignored code
    step(0, 1, 6'b000110, 0, 0, 3, 0, 0, 0, 0);

    // Number reset and fill command in one cycle
    ec_num++; ec_fill++;
    step(0, 1, 6'b110000, 1, 0, 3, 1, 1, 0, 0);

    // Fields without chan_b_valid are ignored
    step(0, 0, 6'b001010, 1, 0, 3, 1, 0, 0, 0);

    // Back-to-back timestamp resets; CNT_W=2 copy saturates at 3
    for (int i = 0; i < 6; i++) begin
      ec_ts++;
      step(0, 1, 6'b001010, 0, 0, 3, 1, 0, 1, 0);
    end

    // Reset while pending discards the staged fill
    clr();
    step(1, 1, 6'b111000, 1, 0, 1, 0, 0, 0, 0);
    repeat (3) step(0, 0, 6'b000000, 0, 1, 1, 0, 0, 0, 0);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ttc_chanb_cmd_decoder.md
# ttc_chanb_cmd_decoder

Parametrised TTC Channel B broadcast-command decoder sitting between the TTC decoder and the trigger manager. It has three jobs:
- Decode trigger-number reset, timestamp reset and fill-type commands into registered single-cycle strobes.
- Stage fill-type changes and apply them only when the trigger manager reports it is between fills.
- Keep optional saturating command/error counters for slow-control readout.

## Interface
Parameters:
- FILL_TYPE_W, 2: fill-type field width, legal values 2 or 3. The field is chan_b_info[4 -: FILL_TYPE_W].
- DEFAULT_FILL, 1: fill_type value after reset (muon fill).
- CNT_W, 16: width of each statistics counter.

Ports:
- clk  in  1  user clock; sole clock domain.
- reset  in  1  synchronous, active-high reset.
- chan_b_info  in  6  Brcst[7:2] from the TTC decoder.
- evt_count_reset  in  1  event-counter-reset flag from the TTC decoder.
- chan_b_valid  in  1  BrcstStr qualifier; command fields are sampled only when this is high.
- trig_idle  in  1  trigger manager is between fills; a staged fill type may be applied.
- fill_type  out  FILL_TYPE_W  active fill type.
- fill_pending  out  1  a staged fill type is waiting for trig_idle.
- reset_trig_num  out  1  registered 1-cycle strobe.
- reset_trig_timestamp  out  1  registered 1-cycle strobe.
- cmd_error  out  1  1-cycle strobe on an illegal fill command.
- num_fill_cmds, num_ts_resets, num_num_resets, num_errors, num_overwrites  out  CNT_W each  saturating counters.

## Operation
Decode, qualified by chan_b_valid:
- Number reset when evt_count_reset = 1.
- Timestamp reset when chan_b_info[5:3] = 3'b001 and chan_b_info[1] = 1.
- Fill command when chan_b_info[5] = 1 and chan_b_info[1] = 0.
  - A field value of zero is illegal: the command is dropped, cmd_error pulses and num_errors increments.
- All other codes are ignored silently.
- Several decodes can be true in the same cycle. All of them act independently in that cycle.

Fill-type FSM, two states:
- IDLE:
  - A legal fill command loads pend_reg with the field value.
  - Goes to PENDING.
- PENDING:
  - fill_pending = 1.
  - When trig_idle = 1: fill_type <= pend_reg and go to IDLE.
  - A new legal fill command while in PENDING overwrites pend_reg (latest wins) and increments num_overwrites.
  - If trig_idle and a new command arrive in the same cycle:
    - fill_type takes the old pend_reg.
    - pend_reg takes the new value.
    - The FSM stays in PENDING. No overwrite is counted.
- A command equal to the current fill_type is still staged and counted.

Counters:
- Each counter increments by 1 per qualifying event.
- Each counter saturates at 2^CNT_W−1 and never wraps.

## Timing
- Strobes (reset_trig_num, reset_trig_timestamp, cmd_error) assert exactly one cycle after the chan_b_valid cycle, for one cycle.
- Back-to-back valid cycles produce back-to-back strobes.
- A legal fill command in cycle N:
  - fill_pending is high from N+1.
  - fill_type changes at the earliest in N+2, i.e. the cycle after the first cycle ≥ N+1 in which trig_idle = 1 while in PENDING.
- Counters update one cycle after their event (the same edge as the strobes).
- Reset values:
  - fill_type = DEFAULT_FILL.
  - fill_pending = 0.
  - All strobes = 0.
  - All counters = 0.
  - FSM = IDLE.
  - pend_reg = DEFAULT_FILL.
- Reset asserted mid-operation discards any staged fill type. Inputs are ignored while reset is high.

## Configuration
- CHANB_CMD_COUNTERS_EN defined: all five counters are implemented as described.
- CHANB_CMD_COUNTERS_EN undefined:
  - Counter registers are not built and all num_* outputs are tied to 0.
  - Strobes, the FSM and cmd_error are unchanged.

## Structure
- Package ttc_chanb_pkg holds:
  - Bit-position constants: FLAG_BIT = 1, FILL_SEL_BIT = 5.
  - The timestamp pattern 3'b001.
  - FSM state encodings ST_IDLE and ST_PENDING.
- Sub-module chanb_sat_counter (parameter W; ports clk, reset, inc, count) is instantiated five times inside the CHANB_CMD_COUNTERS_EN guard.

## Test plan
- Reset, then idle for 10 cycles:
  - fill_type = 1, fill_pending = 0, no strobes, counters 0.
- chan_b_valid with chan_b_info = 6'b001010 and evt_count_reset = 1 for one cycle:
  - reset_trig_timestamp and reset_trig_num both high for exactly one cycle, one cycle later.
  - num_ts_resets = num_num_resets = 1.
- trig_idle = 0; fill command 6'b110000 (field 2); then 5 cycles later raise trig_idle:
  - fill_pending = 1 throughout the wait.
  - fill_type becomes 2 the cycle after trig_idle rises.
  - fill_pending then drops.
- Fill commands field 2 then field 3 with trig_idle = 0, then trig_idle = 1:
  - fill_type = 3 and num_overwrites = 1.
- Fill command field 0 (6'b100000):
  - cmd_error pulses once, num_errors = 1, fill_type and fill_pending unchanged.
- Run with CNT_W = 2 and issue 6 timestamp resets:
  - num_ts_resets holds at 3.
- Apply reset while fill_pending = 1:
  - Next cycle fill_type = 1 and fill_pending = 0.
